// File: rtl/tensor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_pkg : constants, tile types and drain FSM encoding shared across the
//              tensor core and its result drain.  Rev 1.0
// ----------------------------------------------------------------------------
package tensor_pkg;

  localparam int TC_SIZE      = 4;
  localparam int TC_ACC_WIDTH = 32;

  typedef logic [TC_SIZE-1:0][TC_ACC_WIDTH-1:0]              tc_acc_row_t;
  typedef logic [TC_SIZE-1:0][TC_SIZE-1:0][TC_ACC_WIDTH-1:0] tc_acc_tile_t;

  typedef enum logic [0:0] {
    TD_IDLE  = 1'b0,
    TD_DRAIN = 1'b1
  } td_state_e;

endpackage
`default_nettype wire

// File: rtl/tensor_result_drain_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_result_drain_if : tile strobe in, row-per-cycle write port out.
//                          Rev 1.0
// ----------------------------------------------------------------------------
interface tensor_result_drain_if
  import tensor_pkg::*;
#(
  parameter int ACC_WIDTH = TC_ACC_WIDTH,
  parameter int SIZE      = TC_SIZE,
  parameter int TAG_WIDTH = 4
);
  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic                                   in_valid;
  logic [SIZE-1:0][SIZE-1:0][ACC_WIDTH-1:0] in_matrix;
  logic                                   wr_valid;
  logic                                   wr_ready;
  logic [SIZE-1:0][ACC_WIDTH-1:0]         wr_data;
  logic [RW-1:0]                          wr_row;
  logic                                   wr_last;
  logic [TAG_WIDTH-1:0]                   wr_tag;
  logic                                   busy;
  logic                                   overflow;

  modport master (
    output in_valid, in_matrix, wr_ready,
    input  wr_valid, wr_data, wr_row, wr_last, wr_tag, busy, overflow
  );

  modport slave (
    input  in_valid, in_matrix, wr_ready,
    output wr_valid, wr_data, wr_row, wr_last, wr_tag, busy, overflow
  );

endinterface
`default_nettype wire

// File: rtl/tensor_tile_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_tile_buf : 2-entry tile store with pointers, occupancy and space rule.
//                   Rev 1.0
// ----------------------------------------------------------------------------
module tensor_tile_buf
  import tensor_pkg::*;
#(
  parameter int ACC_WIDTH = TC_ACC_WIDTH,
  parameter int SIZE      = TC_SIZE,
  parameter int TAG_WIDTH = 4,
  parameter int RW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     push,
  input  logic [SIZE-1:0][SIZE-1:0][ACC_WIDTH-1:0] push_tile,
  input  logic [TAG_WIDTH-1:0]                     push_tag,
  input  logic                                     pop_tile,
  input  logic [RW-1:0]                            rd_row,
  output logic [SIZE-1:0][ACC_WIDTH-1:0]           rd_data,
  output logic [TAG_WIDTH-1:0]                     rd_tag,
  output logic [1:0]                               count,
  output logic                                     space
);

  logic [SIZE-1:0][SIZE-1:0][ACC_WIDTH-1:0] mem     [2];
  logic [TAG_WIDTH-1:0]                     tag_mem [2];
  logic                                     wr_ptr;
  logic                                     rd_ptr;

  // A full buffer still has room when the head tile retires this very cycle.
  assign space = (count < 2'd2) || pop_tile;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]     <= push_tile;
      tag_mem[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)     wr_ptr <= ~wr_ptr;
      if (pop_tile) rd_ptr <= ~rd_ptr;
      case ({push, pop_tile})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr][rd_row];
  assign rd_tag  = tag_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/tensor_result_drain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tensor_result_drain : buffers completed accumulator tiles and streams them
//                       row by row to the register-file write port. Rev 1.0
// ----------------------------------------------------------------------------
module tensor_result_drain
  import tensor_pkg::*;
#(
  parameter int ACC_WIDTH = TC_ACC_WIDTH,
  parameter int SIZE      = TC_SIZE,
  parameter int TAG_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  tensor_result_drain_if.slave dif
);

  localparam int              RW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [RW-1:0]   LAST_ROW = RW'(SIZE - 1);
  localparam logic [0:0]      ST_IDLE  = TD_IDLE;
  localparam logic [0:0]      ST_DRAIN = TD_DRAIN;

  logic [0:0]                     state;
  logic [0:0]                     state_next;
  logic [RW-1:0]                  row_idx;
  logic [TAG_WIDTH-1:0]           tag_cnt;
  logic                           overflow_q;
  logic                           pop;
  logic                           pop_tile;
  logic                           push;
  logic                           space;
  logic [1:0]                     count;
  logic [SIZE-1:0][ACC_WIDTH-1:0] head_row;
  logic [TAG_WIDTH-1:0]           head_tag;

  assign pop      = (state == ST_DRAIN) && dif.wr_ready;
  assign pop_tile = pop && (row_idx == LAST_ROW);
  assign push     = dif.in_valid && space;

  tensor_tile_buf #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIZE      (SIZE),
    .TAG_WIDTH (TAG_WIDTH),
    .RW        (RW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_tile (dif.in_matrix),
    .push_tag  (tag_cnt),
    .pop_tile  (pop_tile),
    .rd_row    (row_idx),
    .rd_data   (head_row),
    .rd_tag    (head_tag),
    .count     (count),
    .space     (space)
  );

  // Entering DRAIN on the push edge itself gives row 0 in the very next cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (push) state_next = ST_DRAIN;
      ST_DRAIN: if (pop_tile && (count == 2'd1) && !push) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row_idx    <= '0;
      tag_cnt    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_next;
      if (pop)                       row_idx <= pop_tile ? '0 : row_idx + RW'(1);
      if (push)                      tag_cnt <= tag_cnt + TAG_WIDTH'(1);
      if (dif.in_valid && !space)    overflow_q <= 1'b1;
    end
  end

  assign dif.wr_valid = (state == ST_DRAIN);
  assign dif.wr_data  = dif.wr_valid ? head_row : '0;
  assign dif.wr_row   = row_idx;
  assign dif.wr_last  = dif.wr_valid && (row_idx == LAST_ROW);
  assign dif.wr_tag   = dif.wr_valid ? head_tag : '0;
  assign dif.busy     = (count != 2'd0);
  assign dif.overflow = overflow_q;

endmodule
`default_nettype wire
